dmem_sram_like_bridge: RTL
==========================

DMEM_SRAM_LIKE_BRIDGE -- requirements
Module: dmem_sram_like_bridge

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 data_sram_en  in  1  M-stage memory request (already exception-gated).
REQ-005 data_sram_rlen  in  2  access size: 0=byte, 1=half, 2=word.
REQ-006 data_sram_wen  in  4  byte write strobes; 0000 = read.
REQ-007 data_sram_addr  in  32  byte address.
REQ-008 data_sram_wdata  in  32  lane-aligned write data.
REQ-009 data_sram_rdata  out  32  read word returned to M stage.
REQ-010 pipe_advance  in  1  M-stage instruction leaves M this cycle.
REQ-011 stall_req  out  1  hold pipeline; access not complete.
REQ-012 data_req  out  1  bus request valid.
REQ-013 data_wr  out  1  1=write, 0=read.
REQ-014 data_size  out  2  copy of latched rlen.
REQ-015 data_addr  out  32  latched address.
REQ-016 data_wstrb  out  4  latched wen.
REQ-017 data_wdata  out  32  latched wdata.
REQ-018 data_addr_ok  in  1  bus accepted request.
REQ-019 data_data_ok  in  1  bus completed access; rdata valid for reads.
REQ-020 data_rdata  in  32  bus read data.

Function
REQ-021 FSM states SHALL be IDLE, ADDR, DATA, DONE.
REQ-022 IDLE: data_sram_en=1 -> latch rlen, wen, addr, wdata; go ADDR; else stay.
REQ-023 ADDR: data_req=1 with latched fields; data_addr_ok=1 -> DATA; else stay, fields stable.
REQ-024 data_req SHALL be 0 in every state other than ADDR.
REQ-025 data_wr SHALL equal OR of latched wen; data_wstrb, data_size, data_addr, data_wdata SHALL be the latched values.
REQ-026 DATA: data_data_ok=1 -> capture data_rdata into rdata register (reads only; writes leave it unchanged); go DONE.
REQ-027 data_data_ok in IDLE, ADDR or DONE is a protocol violation and SHALL be ignored.
REQ-028 DONE: pipe_advance=1 -> IDLE; else stay without reissuing the access.
REQ-029 stall_req SHALL be (state==IDLE & data_sram_en) | state==ADDR | state==DATA; 0 in DONE.
REQ-030 data_sram_rdata SHALL always drive the rdata register.
REQ-031 Minimum latency: en seen at T, data_req at T+1, addr_ok at T+1, data_ok at T+2, DONE and stall_req=0 at T+3.
REQ-032 Input changes while in ADDR/DATA/DONE SHALL NOT affect latched fields.
REQ-033 Back-to-back: leaving DONE at T leaves IDLE at T+1; a new en there starts a new access.
REQ-034 Exactly one bus request SHALL be issued per accepted access.

Reset
REQ-035 resetn=0 SHALL force IDLE, rdata register and latched fields to 0, and data_req, data_wr, stall_req to 0, regardless of clk.
REQ-036 Reset mid-access (ADDR or DATA) SHALL abandon the access; no completion reported after release.
REQ-037 After release, first en SHALL start a fresh access from IDLE.

Verification
REQ-038 Word read: en=1, rlen=2, wen=0, addr=0x1000; addr_ok same cycle as req, data_ok next cycle, data_rdata=0xDEADBEEF -> data_wr=0, data_size=2; stall_req high 3 cycles; data_sram_rdata=0xDEADBEEF in DONE.
REQ-039 Byte write: wen=0100, addr=0x2002, wdata=0x00AB0000 -> data_wr=1, data_wstrb=0100, data_size=0; data_addr=0x2002 held through 4 cycles with addr_ok low; one request only.
REQ-040 DONE hold: pipe_advance=0 for 5 cycles after data_ok -> state stays DONE, stall_req=0, data_req=0, rdata unchanged; pipe_advance=1 -> IDLE.
REQ-041 Latched stability: change data_sram_addr to 0xFFFF0000 while in ADDR -> data_addr keeps original value.
REQ-042 Reset in DATA: resetn low before data_ok -> all outputs 0; late data_ok ignored; next en issues fresh request.
REQ-043 Back-to-back read then write: second access issued one cycle after leaving DONE with correct fields.

Source files
------------

// File: rtl/dmem_sram_like_bridge.sv
// ---------------------------------------------------------------------------
// dmem_sram_like_bridge
//
// Converts the M-stage single-cycle SRAM-style data memory request into a
// two-phase handshake bus transaction (address phase / data phase).  The
// request fields are latched when the request is first seen, so the pipeline
// may change its inputs freely while the bridge holds the pipeline stalled.
// After the data phase the bridge parks in DONE until the instruction leaves
// M, which guarantees one bus access per memory instruction even if the
// pipeline stays frozen by other hazards.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   data_sram_en             M-stage memory request
//   data_sram_rlen[1:0]      access size (0 byte, 1 half, 2 word)
//   data_sram_wen[3:0]       byte write strobes, 0000 = read
//   data_sram_addr[31:0]     byte address
//   data_sram_wdata[31:0]    lane-aligned write data
//   data_sram_rdata[31:0]    read word returned to M stage
//   pipe_advance             M-stage instruction leaves M this cycle
//   stall_req                hold the pipeline, access not complete
//   data_req                 bus request valid (address phase)
//   data_wr                  1 = write, 0 = read
//   data_size[1:0]           latched access size
//   data_addr[31:0]          latched address
//   data_wstrb[3:0]          latched byte strobes
//   data_wdata[31:0]         latched write data
//   data_addr_ok             bus accepted the request
//   data_data_ok             bus completed the access
//   data_rdata[31:0]         bus read data
// ---------------------------------------------------------------------------
module dmem_sram_like_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [1:0]  data_sram_rlen,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic        pipe_advance,
    output logic        stall_req,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;

    logic [1:0]  size_q,  size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        is_write;

    // A request is only taken from IDLE; in every other state the pipeline
    // is either stalled or the access is already finished.
    assign accept   = (state_q == IDLE) && data_sram_en;
    assign is_write = |wstrb_q;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (data_sram_en) state_d = ADDR;
            ADDR: if (data_addr_ok) state_d = DATA;
            // data_data_ok outside DATA is a protocol violation; only this
            // arm looks at it, so it is ignored everywhere else.
            DATA: if (data_data_ok) state_d = DONE;
            DONE: if (pipe_advance) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        data_req        = (state_q == ADDR);
        data_wr         = is_write;
        data_size       = size_q;
        data_addr       = addr_q;
        data_wstrb      = wstrb_q;
        data_wdata      = wdata_q;
        data_sram_rdata = rdata_q;
        // Gated by resetn so the pipeline is released immediately while
        // reset is held, even if the M stage keeps asserting a request.
        stall_req       = resetn && (accept || (state_q == ADDR) || (state_q == DATA));
    end

    // -----------------------------------------------------------------------
    // Request latch and read-data capture
    // -----------------------------------------------------------------------
    always_comb begin
        size_d  = size_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        if (accept) begin
            size_d  = data_sram_rlen;
            wstrb_d = data_sram_wen;
            addr_d  = data_sram_addr;
            wdata_d = data_sram_wdata;
        end

        // Writes complete without returning data; keep the last read word.
        if ((state_q == DATA) && data_data_ok && !is_write) begin
            rdata_d = data_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            size_q  <= '0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            size_q  <= size_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
